// File: rtl/high_radix_divider.sv
// Purpose : radix-4 restoring unsigned divider, 32-bit dividend / 16-bit divisor -> 16-bit quotient + remainder.
// Latency : 8 cycles from the accepting edge to done (1 cycle for the error path when HRD_ERR_CHECK_EN is defined).
// Backpr. : start is sampled only while idle; a start seen while busy is dropped, not queued.
//
// Ports:
//   clk, reset (async, active-low)
//   start, dividend[31:0], divisor[15:0]      request and operands, captured on the accepting edge
//   busy, done                                division in progress / one-cycle completion pulse
//   quotient[15:0], remainder[15:0]           registered results, held until the next completion
//   div_by_zero, overflow                     error flags, valid with done
//
// Optional feature macro: HRD_ERR_CHECK_EN
//   defined   : divisor==0 or dividend[31:16]>=divisor finishes one cycle after acceptance with
//               all-ones results and the matching error flag set.
//   undefined : flags tied to 0; every request takes the full 8 steps and the caller must keep
//               dividend[31:16] < divisor for meaningful results.
module high_radix_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] d1_q, d1_d;         // D
    logic [17:0] d2_q, d2_d;         // 2D
    logic [17:0] d3_q, d3_d;         // 3D
    logic [15:0] r_q, r_d;           // partial remainder, stays below D while the input precondition holds
    logic [15:0] lo_q, lo_d;         // remaining dividend bits, consumed two at a time from the MSB end
    logic [15:0] quo_q, quo_d;       // quotient digits accumulated from the LSB end
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;

    // Datapath for one radix-4 step
    logic [17:0] t;
    logic [1:0]  q_dig;
    logic [15:0] qd_lo;
    logic [15:0] r_next;
    logic [15:0] quo_next;

    always_comb begin
        t = {r_q, lo_q[15:14]};
        if (t >= d3_q) begin
            q_dig = 2'd3;
            qd_lo = d3_q[15:0];
        end else if (t >= d2_q) begin
            q_dig = 2'd2;
            qd_lo = d2_q[15:0];
        end else if (t >= d1_q) begin
            q_dig = 2'd1;
            qd_lo = d1_q[15:0];
        end else begin
            q_dig = 2'd0;
            qd_lo = 16'd0;
        end
        // T - q*D < D fits in 16 bits, so the low 16 bits of the modular difference are exact.
        r_next   = t[15:0] - qd_lo;
        quo_next = {quo_q[13:0], q_dig};
    end

`ifdef HRD_ERR_CHECK_EN
    logic err_q, err_d;              // request was rejected at acceptance
    logic dz_pend_q, dz_pend_d;      // the rejection cause was a zero divisor
    logic dbz_q, dbz_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        d3_d        = d3_q;
        r_d         = r_q;
        lo_d        = lo_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef HRD_ERR_CHECK_EN
        err_d       = err_q;
        dz_pend_d   = dz_pend_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    d1_d    = {2'b00, divisor};
                    d2_d    = {1'b0, divisor, 1'b0};
                    d3_d    = {2'b00, divisor} + {1'b0, divisor, 1'b0};
                    r_d     = dividend[31:16];
                    lo_d    = dividend[15:0];
                    quo_d   = 16'd0;
                    cnt_d   = 3'd7;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef HRD_ERR_CHECK_EN
                    dz_pend_d = (divisor == 16'd0);
                    err_d     = (divisor == 16'd0) || (dividend[31:16] >= divisor);
`endif
                end
            end
            RUN: begin
`ifdef HRD_ERR_CHECK_EN
                if (err_q) begin
                    quotient_d  = 16'hFFFF;
                    remainder_d = 16'hFFFF;
                    dbz_d       = dz_pend_q;
                    ovf_d       = !dz_pend_q;
                    err_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else
`endif
                begin
                    r_d   = r_next;
                    lo_d  = {lo_q[13:0], 2'b00};
                    quo_d = quo_next;
                    if (cnt_q == 3'd0) begin
                        quotient_d  = quo_next;
                        remainder_d = r_next;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
`ifdef HRD_ERR_CHECK_EN
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            d1_q        <= 18'd0;
            d2_q        <= 18'd0;
            d3_q        <= 18'd0;
            r_q         <= 16'd0;
            lo_q        <= 16'd0;
            quo_q       <= 16'd0;
            cnt_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
`ifdef HRD_ERR_CHECK_EN
            err_q       <= 1'b0;
            dz_pend_q   <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d3_q        <= d3_d;
            r_q         <= r_d;
            lo_q        <= lo_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef HRD_ERR_CHECK_EN
            err_q       <= err_d;
            dz_pend_q   <= dz_pend_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef HRD_ERR_CHECK_EN
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
`else
    assign div_by_zero = 1'b0;
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_high_radix_divider.sv
module tb_high_radix_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    high_radix_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        logic        chk_val;   // compare quotient/remainder (off for unspecified results)
        int          cyc;       // clock edge at which done must be seen
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at edge %0d expected no pending result", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_edge", cyc, e.cyc);
                check("busy_at_done", {31'd0, busy}, 32'd0);
                if (e.chk_val) begin
                    check("quotient", {16'd0, quotient}, {16'd0, e.q});
                    check("remainder", {16'd0, remainder}, {16'd0, e.r});
                end
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                check("overflow", {31'd0, overflow}, {31'd0, e.ov});
            end
        end
    end

    // Present a request as soon as the DUT is idle; record the expected result against the accept edge.
    task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eov, input logic chk_val,
                         input int lat, input bit hold, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: busy still 1 after %0d cycles, expected 0", n);
        end
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        if (push) begin
            e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.chk_val = chk_val;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        if (!hold) start = 1'b0;
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single division: 255*255 / 255
        issue(32'd65025, 16'd255, 16'd255, 16'd0, 1'b0, 1'b0, 1'b1, 8, 0, 1);

        // Back-to-back with start held high; each accepted on the done cycle of the previous one
        issue(32'd16384, 16'd128, 16'd128, 16'd0,  1'b0, 1'b0, 1'b1, 8, 1, 1);
        issue(32'd0,     16'd128, 16'd0,   16'd0,  1'b0, 1'b0, 1'b1, 8, 1, 1);
        issue(32'd125,   16'd5,   16'd25,  16'd0,  1'b0, 1'b0, 1'b1, 8, 1, 1);
        issue(32'd4095,  16'd36,  16'd113, 16'd27, 1'b0, 1'b0, 1'b1, 8, 0, 1);

        // Start pulses during RUN are ignored
        issue(32'd810, 16'd10, 16'd81, 16'd0, 1'b0, 1'b0, 1'b1, 8, 0, 1);
        @(negedge clk);
        @(negedge clk);
        dividend = 32'd999; divisor = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation aborts without a done
        issue(32'd4096, 16'd64, 16'd64, 16'd0, 1'b0, 1'b0, 1'b1, 8, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", {16'd0, quotient}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_busy_after", {31'd0, busy}, 32'd0);

        issue(32'd363, 16'd33, 16'd11, 16'd0, 1'b0, 1'b0, 1'b1, 8, 0, 1);

`ifdef HRD_ERR_CHECK_EN
        issue(32'd1000, 16'd0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1, 0, 1);
        issue(32'h0010_0000, 16'd16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1, 0, 1);
        issue(32'd7, 16'd2, 16'd3, 16'd1, 1'b0, 1'b0, 1'b1, 8, 0, 1);
`else
        // Precondition violated: results unspecified, timing and flags are not
        issue(32'd1000, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8, 0, 1);
        issue(32'd7, 16'd2, 16'd3, 16'd1, 1'b0, 1'b0, 1'b1, 8, 0, 1);
`endif

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check("pending_results", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
